// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared state encoding and width helper for the SAR search engine
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        DONE = 2'd2
    } sar_state_t;

    // A single-bit search still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sar_search.sv
// rtl/sar_search.sv - successive-approximation search driving an external magnitude comparator
module sar_search
    import sar_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         lt,
    output logic [N-1:0] trial,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int IW = idx_width(N);
    localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);
    localparam logic [N-1:0]  ONE     = N'(1);

    sar_state_t      state_q, state_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [N-1:0]    result_q, result_d;
    logic [N-1:0]    bit_mask;

    assign bit_mask = ONE << idx_q;
    assign result   = result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            idx_q    <= IDX_TOP;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = result_q;
        trial    = '0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = TEST;
                    acc_d   = '0;
                    idx_d   = IDX_TOP;
                end
            end
            TEST: begin
                busy  = 1'b1;
                // Lower bits of acc are still zero here, so OR cannot carry.
                trial = acc_q | bit_mask;
                acc_d = lt ? acc_q : (acc_q | bit_mask);
                if (idx_q == '0) begin
                    state_d  = DONE;
                    result_d = acc_d;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = TEST;
                    acc_d   = '0;
                    idx_d   = IDX_TOP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sar_search.sv
// tb/tb_sar_search.sv - directed scoreboard bench for sar_search with an inline comparator
module tb_sar_search;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         lt;
    logic [N-1:0] trial;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic [N-1:0] hidden;

    int n_tests = 0;
    int n_fail  = 0;

    logic [N-1:0] trial_q[$];
    logic [N-1:0] res_q[$];

    always #5 clk = ~clk;

    // Comparator: a = hidden operand, b = trial, y = (a < b).
    assign lt = (hidden < trial);

    sar_search #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .lt     (lt),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_expect(input logic [N-1:0] h);
        logic [N-1:0] acc;
        logic [N-1:0] t;
        acc = '0;
        for (int i = N - 1; i >= 0; i--) begin
            t = acc | (N'(1) << i);
            trial_q.push_back(t);
            if (h >= t) acc = t;
        end
        res_q.push_back(h);
    endtask

    task automatic run_search(input logic [N-1:0] h);
        int cyc;
        hidden = h;
        trial_q.delete();
        res_q.delete();
        push_expect(h);
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 20) begin
            if (busy) begin
                if (trial_q.size() > 0) check("trial", trial, trial_q.pop_front());
                else check("extra_busy", busy, 1'b0);
            end
            step();
            cyc++;
        end
        check("done_seen", done, 1'b1);
        check("latency", cyc, N + 1);
        check("busy_in_done", busy, 1'b0);
        check("trial_in_done", trial, '0);
        check("result", result, (res_q.size() > 0) ? res_q.pop_front() : 'x);
        step();
        check("idle_done", done, 1'b0);
        check("idle_trial", trial, '0);
        check("idle_result_hold", result, h);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        hidden = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_trial", trial, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, '0);
        step();

        run_search(4'b0101);
        run_search(4'b0000);
        run_search(4'b1111);

        // start held high: TEST ignores it, DONE restarts with no idle gap
        hidden = 4'b1010;
        trial_q.delete();
        res_q.delete();
        for (int s = 0; s < 3; s++) push_expect(4'b1010);
        start = 1'b1;
        step();
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < N; i++) begin
                check("bb_busy", busy, 1'b1);
                check("bb_done_low", done, 1'b0);
                check("bb_trial", trial, (trial_q.size() > 0) ? trial_q.pop_front() : 'x);
                step();
            end
            check("bb_done", done, 1'b1);
            check("bb_busy_low", busy, 1'b0);
            check("bb_result", result, (res_q.size() > 0) ? res_q.pop_front() : 'x);
            if (s == 2) start = 1'b0;
            step();
        end
        check("bb_idle_busy", busy, 1'b0);
        check("bb_idle_done", done, 1'b0);
        step();

        // reset in the third TEST cycle, with start on the same edge
        hidden = 4'b0110;
        start  = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("pre_rst_busy", busy, 1'b1);
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_trial", trial, '0);
        check("post_rst_result", result, '0);
        check("post_rst_done", done, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("no_done_after_rst", done, 1'b0);
            check("idle_after_rst", busy, 1'b0);
        end
        run_search(4'b0110);

        for (int h = 0; h < (1 << N); h++) begin
            run_search(N'(h));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
